// File: rtl/rf_dumper.sv
// Register-file dumper: walks a (possibly wrapping) index range, reading each register
// asynchronously and presenting it as a valid/ready beat stream, then pulses done.
module rf_dumper (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  first_addr_i,
  input  logic [4:0]  last_addr_i,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [4:0]  dump_addr_o,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  end_q, end_d;
  logic [4:0]  hold_addr_q, hold_addr_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        is_last;

  assign is_last = (hold_addr_q == end_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      end_q       <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      end_q       <= end_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    end_d       = end_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d   = first_addr_i;
          end_d   = last_addr_i;
          state_d = StRead;
        end
      end
      StRead: begin
        // Snapshot the value now so later register-file writes cannot disturb the beat.
        hold_addr_d = cnt_q;
        hold_data_d = rf_data_i;
        state_d     = StSend;
      end
      StSend: begin
        if (dump_ready_i) begin
          if (is_last) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = StRead;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rf_addr_o    = '0;
    dump_valid_o = 1'b0;
    dump_last_o  = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != StIdle);
    dump_addr_o  = hold_addr_q;
    dump_data_o  = hold_data_q;
    unique case (state_q)
      StRead: rf_addr_o = cnt_q;
      StSend: begin
        rf_addr_o    = cnt_q;
        dump_valid_o = 1'b1;
        dump_last_o  = is_last;
      end
      StDone: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_dumper.sv
// Bench for rf_dumper: table-driven ranges, hand-written corner sequences and random dumps,
// all checked against a queue-free range model with an array standing in for the register file.
module tb_rf_dumper;

  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic [4:0]  first_addr, last_addr, rf_addr, dump_addr;
  logic [31:0] rf_data, dump_data;
  logic        dump_valid, dump_last, busy, done;
  logic [31:0] rf_mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_data = rf_mem[rf_addr];

  rf_dumper dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .first_addr_i (first_addr),
    .last_addr_i  (last_addr),
    .rf_addr_o    (rf_addr),
    .rf_data_i    (rf_data),
    .dump_valid_o (dump_valid),
    .dump_ready_i (ready),
    .dump_addr_o  (dump_addr),
    .dump_data_o  (dump_data),
    .dump_last_o  (dump_last),
    .busy_o       (busy),
    .done_o       (done)
  );

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         beats;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one dump from idle and checks every beat; returns the number of handshakes seen.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int ready_pct,
                          input bit poke_start, output int beats);
    int         exp_n;
    int         cyc;
    bit         done_seen;
    bit         exp_done;
    logic [4:0] ea;
    exp_n     = ((int'(l) - int'(f) + 32) % 32) + 1;
    beats     = 0;
    cyc       = 0;
    done_seen = 0;
    exp_done  = 0;
    start = 1'b1; first_addr = f; last_addr = l; ready = 1'b0;
    step();
    start = 1'b0;
    check("read_cycle_valid", {31'd0, dump_valid}, 32'd0);
    check("read_cycle_busy", {31'd0, busy}, 32'd1);
    check("read_cycle_rf_addr", {27'd0, rf_addr}, {27'd0, f});
    step();
    check("first_beat_latency", {31'd0, dump_valid}, 32'd1);
    while (!done_seen && cyc < 3000) begin
      ready = ($urandom_range(99) < ready_pct);
      if (poke_start) begin
        start      = 1'b1;
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);
      end
      check("done_timing", {31'd0, done}, {31'd0, exp_done});
      ea       = 5'((int'(f) + beats) % 32);
      exp_done = 0;
      if (dump_valid) begin
        check("beat_addr", {27'd0, dump_addr}, {27'd0, ea});
        check("beat_data", dump_data, rf_mem[ea]);
        check("beat_last", {31'd0, dump_last}, {31'd0, beats == exp_n - 1});
        check("send_rf_addr", {27'd0, rf_addr}, {27'd0, ea});
        if (ready) begin
          exp_done = (beats == exp_n - 1);
          beats++;
        end
      end
      if (done) begin
        done_seen = 1;
        check("done_no_valid", {31'd0, dump_valid}, 32'd0);
        check("done_rf_addr", {27'd0, rf_addr}, 32'd0);
      end
      step();
      cyc++;
    end
    start = 1'b0;
    ready = 1'b0;
    check("dump_completed", {31'd0, done_seen}, 32'd1);
    check("beat_count_model", beats, exp_n);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("idle_no_done", {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[7];
  int   got;

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; first_addr = '0; last_addr = '0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + i;
    rf_mem[0] = 32'h0;
    step();
    start = 1'b1; first_addr = 5'd3; last_addr = 5'd4;
    step();
    start = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, dump_valid}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_last", {31'd0, dump_last}, 32'd0);
    check("reset_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("reset_dump_addr", {27'd0, dump_addr}, 32'd0);
    check("reset_dump_data", dump_data, 32'd0);
    rst = 1'b0;
    step();
    check("idle_stays", {31'd0, busy}, 32'd0);

    // Full dump, ready tied high, x0 reads as zero from the file itself.
    run_dump(5'd0, 5'd31, 100, 1'b0, got);
    check("full_dump_beats", got, 32);

    vecs[0] = '{first: 5'd30, last: 5'd1,  beats: 4};
    vecs[1] = '{first: 5'd5,  last: 5'd5,  beats: 1};
    vecs[2] = '{first: 5'd31, last: 5'd0,  beats: 2};
    vecs[3] = '{first: 5'd10, last: 5'd20, beats: 11};
    vecs[4] = '{first: 5'd0,  last: 5'd0,  beats: 1};
    vecs[5] = '{first: 5'd17, last: 5'd16, beats: 32};
    vecs[6] = '{first: 5'd0,  last: 5'd31, beats: 32};
    rf_mem[0] = 32'hC0FFEE00;
    for (int v = 0; v < 7; v++) begin
      run_dump(vecs[v].first, vecs[v].last, 60, 1'b0, got);
      check("table_beats", got, vecs[v].beats);
    end

    // Backpressure: one beat held for 7 wait cycles.
    rf_mem[5] = 32'hDEADBEEF;
    start = 1'b1; first_addr = 5'd5; last_addr = 5'd5;
    step();
    start = 1'b0;
    step();
    for (int c = 0; c < 8; c++) begin
      ready = (c == 7);
      check("bp_valid", {31'd0, dump_valid}, 32'd1);
      check("bp_addr", {27'd0, dump_addr}, 32'd5);
      check("bp_data", dump_data, 32'hDEADBEEF);
      check("bp_last", {31'd0, dump_last}, 32'd1);
      check("bp_no_done", {31'd0, done}, 32'd0);
      step();
    end
    ready = 1'b0;
    check("bp_done", {31'd0, done}, 32'd1);
    check("bp_done_busy", {31'd0, busy}, 32'd1);
    step();
    check("bp_idle", {31'd0, busy}, 32'd0);
    check("bp_done_once", {31'd0, done}, 32'd0);

    // Snapshot: register write during a stalled beat must not leak through.
    rf_mem[3] = 32'hAAAAAAAA;
    start = 1'b1; first_addr = 5'd3; last_addr = 5'd3;
    step();
    start = 1'b0;
    step();
    rf_mem[3] = 32'h11111111;
    for (int c = 0; c < 3; c++) begin
      check("snap_data", dump_data, 32'hAAAAAAAA);
      step();
    end
    ready = 1'b1;
    check("snap_data_hs", dump_data, 32'hAAAAAAAA);
    step();
    ready = 1'b0;
    check("snap_done", {31'd0, done}, 32'd1);
    step();

    // Reset during SEND of beat 2 of a 0..31 dump.
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    step();
    start = 1'b0;
    step();
    ready = 1'b1;
    step();
    step();
    step();
    ready = 1'b0;
    step();
    check("rst_mid_pre_valid", {31'd0, dump_valid}, 32'd1);
    check("rst_mid_pre_addr", {27'd0, dump_addr}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_rf_addr", {27'd0, rf_addr}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_mid_no_done", {31'd0, done}, 32'd0);
    end
    run_dump(5'd0, 5'd31, 100, 1'b0, got);
    check("rst_mid_redump_beats", got, 32);

    // Start pulses while busy, including during DONE, must be ignored.
    run_dump(5'd7, 5'd9, 70, 1'b1, got);
    check("busy_start_beats", got, 3);

    // Random register contents and ranges.
    for (int r = 0; r < 20; r++) begin
      logic [4:0] rf_first;
      logic [4:0] rf_last;
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      rf_first = 5'($urandom);
      rf_last  = 5'($urandom);
      run_dump(rf_first, rf_last, 50, r[0], got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rf_dumper.md
RF_DUMPER -- requirements
Module: rf_dumper

Interface
REQ-001 SHALL have no parameters; register-file geometry is fixed at 32 x 32 bit with 5-bit addresses.
REQ-002 SHALL have clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have start_i, input, 1: request a dump; sampled only in IDLE.
REQ-005 SHALL have first_addr_i, input, 5: first register index, captured on an accepted start.
REQ-006 SHALL have last_addr_i, input, 5: last register index, captured on an accepted start.
REQ-007 SHALL have rf_addr_o, output, 5: drives the register-file asynchronous read address port.
REQ-008 SHALL have rf_data_i, input, 32: register-file read data, valid in the same cycle as rf_addr_o.
REQ-009 SHALL have dump_valid_o, output, 1: an output beat is presented.
REQ-010 SHALL have dump_ready_i, input, 1: the consumer accepts a beat.
REQ-011 SHALL have dump_addr_o, output, 5: register index of the current beat.
REQ-012 SHALL have dump_data_o, output, 32: register value of the current beat.
REQ-013 SHALL have dump_last_o, output, 1: the current beat is the final one of the dump.
REQ-014 SHALL have busy_o, output, 1: high in any state other than IDLE.
REQ-015 SHALL have done_o, output, 1: one-cycle pulse when a dump completes.

Function
REQ-016 SHALL implement four states: IDLE, READ, SEND and DONE.
REQ-017 IDLE: when start_i=1, SHALL capture first_addr_i into the address counter and last_addr_i into the end register, then go to READ; otherwise SHALL stay in IDLE.
REQ-018 READ (exactly one cycle): rf_addr_o SHALL equal the counter; SHALL capture rf_data_i and the counter into the holding registers; SHALL go to SEND.
REQ-019 SEND: dump_valid_o SHALL be 1, with dump_addr_o and dump_data_o driven from the holding registers.
REQ-020 SEND: dump_last_o SHALL be 1 when the held address equals the end register.
REQ-021 SEND: while dump_ready_i=0, SHALL hold dump_valid_o, dump_addr_o, dump_data_o and dump_last_o stable, with no limit on the number of wait cycles.
REQ-022 SEND with dump_ready_i=1 (handshake): if dump_last_o=1, SHALL go to DONE; otherwise SHALL increment the counter modulo 32 and go to READ.
REQ-023 DONE (exactly one cycle): done_o SHALL be 1; SHALL go to IDLE.
REQ-024 Latency: start accepted at cycle N -> first dump_valid_o=1 at cycle N+2; each beat after a handshake SHALL take at least 2 cycles.
REQ-025 Beat count SHALL be ((last-first) mod 32)+1.
REQ-026 first=last SHALL produce exactly 1 beat.
REQ-027 first>last SHALL wrap 31->0.
REQ-028 first=0, last=31 SHALL produce 32 beats.
REQ-029 Index 0 SHALL be read through rf_data_i like any other index; the register file's hardwired zero SHALL NOT be substituted locally.
REQ-030 Each beat's value SHALL be the value of rf_data_i in that beat's READ cycle; register-file writes after that cycle SHALL NOT alter a held beat.
REQ-031 start_i SHALL be ignored while busy_o=1, including in DONE.
REQ-032 rf_addr_o SHALL be 0 in IDLE and DONE.
REQ-033 rf_addr_o SHALL hold the counter value in SEND.
REQ-034 dump_valid_o SHALL be 0 in every state except SEND.
REQ-035 done_o SHALL be 0 in every state except DONE.

Reset
REQ-036 rst_i=1 at a clock edge SHALL force IDLE from any state, including mid-SEND with a beat pending; the pending beat SHALL be dropped and no done_o pulse issued.
REQ-037 Reset values: dump_valid_o=0, dump_last_o=0, busy_o=0, done_o=0, rf_addr_o=0, dump_addr_o=0, dump_data_o=0, counter=0, end register=0.
REQ-038 rst_i SHALL take priority over start_i in the same cycle.

Verification
REQ-039 Full dump: preload x1..x31=0x100+i, start with first=0, last=31, ready tied 1 -> 32 beats, addr 0..31, data 0 then 0x101..0x11F, last only on addr 31, done_o one cycle after the final handshake.
REQ-040 Wrap: first=30, last=1 -> beats addr 30, 31, 0, 1 in that order; dump_last_o only on addr 1.
REQ-041 Backpressure: first=last=5, x5=0xDEADBEEF, ready held 0 for 7 cycles -> valid, addr 5 and data 0xDEADBEEF stable for 8 cycles; done_o after the handshake.
REQ-042 Snapshot: write x3=0x11111111 while beat addr 3 (captured 0xAAAAAAAA) is stalled -> dump_data_o remains 0xAAAAAAAA.
REQ-043 Reset mid-dump: rst_i pulsed during SEND of beat 2 of 0..31 -> next cycle valid=0, busy=0; no done_o; a new start then dumps normally.
REQ-044 Start while busy: start_i=1 with new first/last during a dump -> ignored; original range completes unchanged.
